// File: rtl/mat_mul_pkg.sv
// mat_mul_pkg: shared state encoding and index/width helpers for the matrix multiplier
package mat_mul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Flat bit offset of element (r,c) in a row-major packed matrix with cols columns of w bits
    function automatic int elem_off(input int r, input int c, input int cols, input int w);
        return (r * cols + c) * w;
    endfunction

    // Accumulator width: full product plus growth for the inner-dimension sum plus one guard bit
    function automatic int acc_width(input int w, input int ca);
        return 2 * w + $clog2(ca) + 1;
    endfunction

endpackage

// File: rtl/mat_mul_mac.sv
// mat_mul_mac: unsigned W-bit multiply-accumulate with clear; output saturates when MMUL_SAT_EN is defined, else truncates
import mat_mul_pkg::*;

module mat_mul_mac #(
    parameter int W  = 8,
    parameter int CA = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res
);

    localparam int AW = acc_width(W, CA);

    logic [AW-1:0]  acc;
    logic [AW-1:0]  sum;
    logic [2*W-1:0] prod;

    assign prod = a * b;
    assign sum  = acc + AW'(prod);

`ifdef MMUL_SAT_EN
    assign res = (|sum[AW-1:W]) ? {W{1'b1}} : sum[W-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^sum[AW-1:W];
    assign res       = sum[W-1:0];
`endif

    // Accumulator: cleared on start and after each finished output element, otherwise adds one product per enabled cycle
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= sum;
    end

endmodule

// File: rtl/mat_mul.sv
// mat_mul: sequential C = A x B, one MAC per clock over a row-major walk of C; MMUL_SAT_EN selects saturating result elements
import mat_mul_pkg::*;

module mat_mul #(
    parameter int RA = 3,
    parameter int CA = 2,
    parameter int RB = 2,
    parameter int CB = 4,
    parameter int W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [RA*CA*W-1:0]  A,
    input  logic [RB*CB*W-1:0]  B,
    output logic [RA*CB*W-1:0]  C,
    output logic                completed
);

    if (RB != CA) begin : g_dim_check
        $fatal(1, "mat_mul: RB (%0d) must equal CA (%0d)", RB, CA);
    end

    localparam int IW = (RA > 1) ? $clog2(RA) : 1;
    localparam int JW = (CB > 1) ? $clog2(CB) : 1;
    localparam int KW = (CA > 1) ? $clog2(CA) : 1;

    state_t state, state_n;

    logic [RA*CA*W-1:0] a_r;
    logic [RB*CB*W-1:0] b_r;
    logic [IW-1:0]      i;
    logic [JW-1:0]      j;
    logic [KW-1:0]      k;
    logic               last_i, last_j, last_k, last_all;
    logic               in_idle, in_compute;
    logic [W-1:0]       a_sel, b_sel, res;

    assign last_i     = i == IW'(RA - 1);
    assign last_j     = j == JW'(CB - 1);
    assign last_k     = k == KW'(CA - 1);
    assign last_all   = last_i && last_j && last_k;
    assign in_idle    = state == IDLE;
    assign in_compute = state == COMPUTE;
    assign a_sel      = a_r[elem_off(int'(i), int'(k), CA, W) +: W];
    assign b_sel      = b_r[elem_off(int'(k), int'(j), CB, W) +: W];

    mat_mul_mac #(.W(W), .CA(CA)) u_mac (
        .clk (clk),
        .rst (rst),
        .clr (in_idle || (in_compute && last_k)),
        .en  (in_compute),
        .a   (a_sel),
        .b   (b_sel),
        .res (res)
    );

    // State register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    // Next state: start on enable, finish on the last MAC, rearm only once enable drops
    always_comb begin
        state_n = state;
        if (in_idle && enable)
            state_n = COMPUTE;
        else if (in_compute && last_all)
            state_n = DONE;
        else if (state == DONE && !enable)
            state_n = IDLE;
    end

    // Operand capture, index walk over (i,j,k), result write-back and completion flag
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r       <= '0;
            b_r       <= '0;
            C         <= '0;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            completed <= 1'b0;
        end else if (in_idle) begin
            completed <= 1'b0;
            if (enable) begin
                a_r <= A;
                b_r <= B;
                i   <= '0;
                j   <= '0;
                k   <= '0;
            end
        end else if (in_compute) begin
            k <= last_k ? '0 : k + KW'(1);
            if (last_k) begin
                C[elem_off(int'(i), int'(j), CB, W) +: W] <= res;
                j <= last_j ? '0 : j + JW'(1);
                if (last_j)
                    i <= last_i ? '0 : i + IW'(1);
            end
            if (last_all)
                completed <= 1'b1;
        end else if (!enable) begin
            completed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mat_mul.sv
// tb_mat_mul: scoreboard bench for mat_mul with a loop-based reference model and directed plus random operations
module tb_mat_mul;

    localparam int RA  = 3;
    localparam int CA  = 2;
    localparam int RB  = 2;
    localparam int CB  = 4;
    localparam int W   = 8;
    localparam int AWD = RA * CA * W;
    localparam int BWD = RB * CB * W;
    localparam int CWD = RA * CB * W;
    localparam int LAT = RA * CB * CA;

    typedef struct {
        logic [CWD-1:0] c;
        int             acc_cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           enable = 1'b0;
    logic [AWD-1:0] a_in = '0;
    logic [BWD-1:0] b_in = '0;
    logic [CWD-1:0] c_out;
    logic           completed;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;
    exp_t q[$];

    mat_mul #(.RA(RA), .CA(CA), .RB(RB), .CB(CB), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .A         (a_in),
        .B         (b_in),
        .C         (c_out),
        .completed (completed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: textbook triple loop with integer sums, then reduced to W bits
    function automatic logic [CWD-1:0] model(input logic [AWD-1:0] a, input logic [BWD-1:0] b);
        logic [CWD-1:0] c;
        longint s;
        c = '0;
        for (int r = 0; r < RA; r++)
            for (int col = 0; col < CB; col++) begin
                s = 0;
                for (int n = 0; n < CA; n++)
                    s += longint'(a[(r*CA+n)*W +: W]) * longint'(b[(n*CB+col)*W +: W]);
`ifdef MMUL_SAT_EN
                if (s > 255) s = 255;
`else
                s = s % 256;
`endif
                c[(r*CB+col)*W +: W] = W'(s);
            end
        return c;
    endfunction

    task automatic check(input string name, input logic [CWD-1:0] got, input logic [CWD-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: on each completed rise, pop the oldest expectation and check result and latency
    always @(negedge clk) begin
        exp_t e;
        if (completed && !prev_done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_completed: got completed=1 want no pending op");
            end else begin
                e = q.pop_front();
                check("result", c_out, e.c);
                checks++;
                if (cyc - e.acc_cyc != LAT) begin
                    errors++;
                    $display("FAIL latency: got %0d want %0d", cyc - e.acc_cyc, LAT);
                end
            end
        end
        prev_done = completed;
    end

    // One full operation: accept, scramble inputs, wait, check DONE hold, drop enable
    task automatic run_op(input logic [AWD-1:0] a, input logic [BWD-1:0] b, input logic [CWD-1:0] want);
        int n;
        a_in   = a;
        b_in   = b;
        enable = 1'b1;
        @(posedge clk);
        #1;
        q.push_back('{want, cyc});
        a_in = AWD'({$urandom, $urandom});
        b_in = BWD'({$urandom, $urandom});
        n = 0;
        while (!completed && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!completed) begin
            errors++;
            $display("FAIL timeout: got completed=0 want 1 within 200 cycles");
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            check("done_hold_c", c_out, want);
            check("done_hold_flag", CWD'(completed), CWD'(1));
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("drop_flag", CWD'(completed), CWD'(0));
        check("drop_c_kept", c_out, want);
    endtask

    initial begin
        logic [AWD-1:0] a;
        logic [BWD-1:0] b;
        repeat (3) @(posedge clk);
        #1;
        check("reset_c", c_out, '0);
        check("reset_flag", CWD'(completed), CWD'(0));
        rst = 1'b0;

        run_op({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6},
               {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
               {8'd11, 8'd14, 8'd17, 8'd20, 8'd23, 8'd30, 8'd37, 8'd44, 8'd35, 8'd46, 8'd57, 8'd68});

        a = {8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1};
        b = BWD'({$urandom, $urandom});
        run_op(a, b, model(a, b));

`ifdef MMUL_SAT_EN
        run_op({AWD{1'b1}}, {BWD{1'b1}}, {RA*CB{8'hFF}});
`else
        run_op({AWD{1'b1}}, {BWD{1'b1}}, {RA*CB{8'h02}});
`endif

        a_in   = AWD'({$urandom, $urandom});
        b_in   = BWD'({$urandom, $urandom});
        enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midop_reset_c", c_out, '0);
        check("midop_reset_flag", CWD'(completed), CWD'(0));
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("midop_no_finish", CWD'(completed), CWD'(0));

        for (int t = 0; t < 10; t++) begin
            a = AWD'({$urandom, $urandom});
            b = BWD'({$urandom, $urandom});
            if (t == 3) a = AWD'({$urandom_range(3, 0), $urandom_range(3, 0)});
            run_op(a, b, model(a, b));
        end

        repeat (5) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_ops: got %0d want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
